// File: rtl/dekatron_pkg.sv
// dekatron_pkg: shared digit width, BCD digit type and controller states.
package dekatron_pkg;
    localparam int DEKATRON_WIDTH = 4;
    typedef logic [DEKATRON_WIDTH-1:0] bcd_t;
    typedef enum logic [1:0] {IDLE, STEP, SETTLE, WRITE} state_t;
endpackage

// File: rtl/dekatron_step_counter_digit.sv
// bcd_digit_step: one decade, combinational +/-1 with ripple carry/borrow and load clamp.
module bcd_digit_step
    import dekatron_pkg::*;
(
    input  logic dec,
    input  bcd_t digit,
    input  logic cin,
    input  bcd_t raw,
    output bcd_t next,
    output logic cout,
    output bcd_t clamped
);
    bcd_t d;
    assign d       = digit > 4'd9 ? 4'd9 : digit;
    assign cout    = cin & (dec ? d == 4'd0 : d == 4'd9);
    assign next    = !cin ? d : dec ? (d == 4'd0 ? 4'd9 : d - 4'd1) : (d == 4'd9 ? 4'd0 : d + 4'd1);
    assign clamped = raw > 4'd9 ? 4'd9 : raw;
endmodule

// File: rtl/dekatron_step_counter.sv
// dekatron_step_counter: BCD up/down step counter with glow-transfer settle and timed parallel write.
// Multi-step Inc/Dec (Steps port honoured) is built only with DEKATRON_STEP_BULK_EN defined.
module dekatron_step_counter
    import dekatron_pkg::*;
#(
    parameter int D_NUM = 3,
    parameter logic TOP_LIMIT_MODE = 1'b0,
    parameter logic [D_NUM*DEKATRON_WIDTH-1:0] TOP_VALUE = {4'd5, 4'd5, 4'd5},
    parameter int SETTLE_CYCLES = 2,
    parameter int WRITE_CYCLES = 10
) (
    input  logic                            Clk,
    input  logic                            Rst_n,
    input  logic                            Request,
    input  logic                            Dec,
    input  logic                            Set,
    input  logic                            SetZero,
    input  logic [3:0]                      Steps,
    input  logic [D_NUM*DEKATRON_WIDTH-1:0] In,
    output logic                            Ready,
    output logic                            Zero,
    output logic                            AtTop,
    output logic                            Wrap,
    output logic [D_NUM*DEKATRON_WIDTH-1:0] Out
);
    localparam int W = D_NUM * DEKATRON_WIDTH;
    localparam logic [W-1:0] LIMIT = TOP_LIMIT_MODE ? TOP_VALUE : {D_NUM{4'd9}};

    state_t state, state_n;
    logic [3:0] rem, steps_eff;
    logic [7:0] cnt;
    logic dec_q, accept, wrap_now;
    logic [W-1:0] ld_q, stepped, clamped, step_val;
    logic [D_NUM:0] carry;

    assign carry[0] = 1'b1;
    for (genvar g = 0; g < D_NUM; g++) begin : g_digit
        bcd_digit_step u_digit (
            .dec(dec_q),
            .digit(Out[g*DEKATRON_WIDTH +: DEKATRON_WIDTH]),
            .cin(carry[g]),
            .raw(In[g*DEKATRON_WIDTH +: DEKATRON_WIDTH]),
            .next(stepped[g*DEKATRON_WIDTH +: DEKATRON_WIDTH]),
            .cout(carry[g+1]),
            .clamped(clamped[g*DEKATRON_WIDTH +: DEKATRON_WIDTH])
        );
    end

`ifdef DEKATRON_STEP_BULK_EN
    assign steps_eff = Steps == 4'd0 ? 4'd1 : Steps;
`else
    logic unused_steps;
    assign unused_steps = ^Steps;
    assign steps_eff = 4'd1;
`endif

    assign Zero   = Out == '0;
    assign AtTop  = Out == LIMIT;
    assign accept = Request & Ready;
    // A carry out of the top decade covers the all-nines wrap when Out sits above TOP_VALUE
    assign wrap_now = dec_q ? Zero : (AtTop | carry[D_NUM]);
    assign step_val = !wrap_now ? stepped : dec_q ? LIMIT : '0;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? ((SetZero | Set) ? WRITE : STEP) : IDLE;
            STEP:    state_n = SETTLE;
            SETTLE:  state_n = cnt != 8'd0 ? SETTLE : rem != 4'd0 ? STEP : IDLE;
            WRITE:   state_n = cnt != 8'd0 ? WRITE : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            Ready <= 1'b1;
            Wrap  <= 1'b0;
            Out   <= '0;
            rem   <= '0;
            cnt   <= '0;
            dec_q <= 1'b0;
            ld_q  <= '0;
        end else begin
            state <= state_n;
            // Ready trails the return to IDLE by one cycle so a finished op is fully settled
            Ready <= state == IDLE && state_n == IDLE;
            Wrap  <= state == STEP && wrap_now;
            if (accept) begin
                dec_q <= Dec;
                rem   <= steps_eff;
                ld_q  <= SetZero ? '0 : clamped;
                cnt   <= 8'(WRITE_CYCLES - 1);
            end
            if (state == STEP) begin
                Out <= step_val;
                rem <= rem - 4'd1;
                cnt <= 8'(SETTLE_CYCLES - 1);
            end
            if ((state == SETTLE || state == WRITE) && cnt != 8'd0)
                cnt <= cnt - 8'd1;
            if (state == WRITE)
                Out <= ld_q;
        end
    end
endmodule

// File: tb/tb_dekatron_step_counter.sv
// tb_dekatron_step_counter: vector table, random ops vs integer model, async reset mid-operation.
module tb_dekatron_step_counter;
    localparam int SC = 2;
    localparam int WC = 10;
`ifdef DEKATRON_STEP_BULK_EN
    localparam bit BULK = 1'b1;
`else
    localparam bit BULK = 1'b0;
`endif

    logic Clk = 1'b0, Rst_n = 1'b0;
    logic Dec = 1'b0, Set = 1'b0, SetZero = 1'b0;
    logic [3:0] Steps = 4'd0;
    logic [11:0] In = 12'd0;
    logic [1:0] req = 2'b00, rdy, zr, at, wr;
    logic [11:0] out0, out1;
    int n_tests = 0, n_fail = 0;
    int mdl[2] = '{0, 0};

    always #5 Clk = ~Clk;

    dekatron_step_counter #(.D_NUM(3), .TOP_LIMIT_MODE(1'b0), .TOP_VALUE(12'h555),
        .SETTLE_CYCLES(SC), .WRITE_CYCLES(WC)) u_nines (
        .Clk(Clk), .Rst_n(Rst_n), .Request(req[0]), .Dec(Dec), .Set(Set), .SetZero(SetZero),
        .Steps(Steps), .In(In), .Ready(rdy[0]), .Zero(zr[0]), .AtTop(at[0]), .Wrap(wr[0]), .Out(out0));

    dekatron_step_counter #(.D_NUM(3), .TOP_LIMIT_MODE(1'b1), .TOP_VALUE(12'h555),
        .SETTLE_CYCLES(SC), .WRITE_CYCLES(WC)) u_top (
        .Clk(Clk), .Rst_n(Rst_n), .Request(req[1]), .Dec(Dec), .Set(Set), .SetZero(SetZero),
        .Steps(Steps), .In(In), .Ready(rdy[1]), .Zero(zr[1]), .AtTop(at[1]), .Wrap(wr[1]), .Out(out1));

    function automatic int cl(input logic [3:0] d);
        return d > 4'd9 ? 9 : int'(d);
    endfunction

    function automatic int b2i(input logic [11:0] b);
        return cl(b[11:8]) * 100 + cl(b[7:4]) * 10 + cl(b[3:0]);
    endfunction

    function automatic logic [11:0] i2b(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // op = {SetZero, Set, Dec}; poke fires a Set request in the middle of the busy window
    task automatic run_op(input int s, input logic [2:0] op, input logic [3:0] st,
                          input logic [11:0] inv, input bit poke);
        int v, w, n, eb, busy, wraps, lim;
        lim = s == 0 ? 999 : 555;
        v = mdl[s];
        w = 0;
        if (op[2] | op[1]) begin
            v = op[2] ? 0 : b2i(inv);
            eb = WC + 1;
        end else begin
            n = BULK ? (st == 4'd0 ? 1 : int'(st)) : 1;
            for (int i = 0; i < n; i++) begin
                if (op[0]) begin
                    if (v == 0) begin v = lim; w++; end else v--;
                end else begin
                    if (v == lim || v == 999) begin v = 0; w++; end else v++;
                end
            end
            eb = n * (1 + SC) + 1;
        end
        @(negedge Clk);
        {SetZero, Set, Dec} = op;
        Steps = st;
        In = inv;
        req[s] = 1'b1;
        @(negedge Clk);
        req[s] = 1'b0;
        {SetZero, Set, Dec} = 3'($urandom);
        Steps = 4'($urandom);
        In = 12'($urandom);
        busy = 0;
        wraps = 0;
        while (rdy[s] == 1'b0 && busy < 300) begin
            busy++;
            wraps += int'(wr[s]);
            req[s] = poke && busy == 3;
            @(negedge Clk);
        end
        req[s] = 1'b0;
        mdl[s] = v;
        chk("out", int'(s == 0 ? out0 : out1), int'(i2b(v)));
        chk("busy", busy, eb);
        chk("wraps", wraps, w);
        chk("zero", int'(zr[s]), int'(v == 0));
        chk("attop", int'(at[s]), int'(v == lim));
    endtask

    typedef struct {
        int s;
        logic [2:0] op;
        logic [3:0] st;
        logic [11:0] inv;
        bit poke;
        logic [11:0] exp_out;
    } vec_t;

    vec_t vt[13];

    initial begin
        vt[0]  = '{0, 3'b000, 4'd1, 12'h000, 1'b0, 12'h001};
        vt[1]  = '{0, 3'b010, 4'd0, 12'h199, 1'b0, 12'h199};
        vt[2]  = '{0, 3'b000, 4'd1, 12'h000, 1'b0, 12'h200};
        vt[3]  = '{0, 3'b110, 4'd0, 12'h777, 1'b0, 12'h000};
        vt[4]  = '{0, 3'b010, 4'd0, 12'hA3F, 1'b1, 12'h939};
        vt[5]  = '{0, 3'b010, 4'd0, 12'h998, 1'b0, 12'h998};
        vt[6]  = '{0, 3'b000, 4'd5, 12'h000, 1'b0, BULK ? 12'h003 : 12'h999};
        vt[7]  = '{1, 3'b010, 4'd0, 12'h555, 1'b0, 12'h555};
        vt[8]  = '{1, 3'b000, 4'd1, 12'h000, 1'b0, 12'h000};
        vt[9]  = '{1, 3'b001, 4'd1, 12'h000, 1'b0, 12'h555};
        vt[10] = '{1, 3'b010, 4'd0, 12'h777, 1'b0, 12'h777};
        vt[11] = '{1, 3'b000, 4'd1, 12'h000, 1'b0, 12'h778};
        vt[12] = '{1, 3'b001, 4'd0, 12'h000, 1'b0, 12'h777};

        repeat (3) @(negedge Clk);
        chk("rst_out", int'(out0), 0);
        chk("rst_ready", int'(rdy), 3);
        chk("rst_zero", int'(zr), 3);
        chk("rst_wrap", int'(wr), 0);
        chk("rst_attop", int'(at), 0);
        Rst_n = 1'b1;
        repeat (2) @(negedge Clk);

        for (int i = 0; i < 13; i++) begin
            run_op(vt[i].s, vt[i].op, vt[i].st, vt[i].inv, vt[i].poke);
            chk($sformatf("vec%0d", i), int'(vt[i].s == 0 ? out0 : out1), int'(vt[i].exp_out));
        end

        for (int i = 0; i < 40; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            run_op(int'($urandom_range(0, 1)),
                   r < 4 ? 3'b000 : r < 8 ? 3'b001 : r < 9 ? 3'b010 : 3'b100,
                   4'($urandom), 12'($urandom), 1'b0);
        end

        run_op(0, 3'b100, 4'd0, 12'h000, 1'b0);
        @(negedge Clk);
        {SetZero, Set, Dec} = 3'b000;
        Steps = 4'd5;
        req[0] = 1'b1;
        @(negedge Clk);
        req[0] = 1'b0;
        repeat (BULK ? 7 : 1) @(negedge Clk);
        chk("pre_rst_out", int'(out0), BULK ? 3 : 1);
        Rst_n = 1'b0;
        #1;
        chk("mid_rst_out", int'(out0), 0);
        chk("mid_rst_ready", int'(rdy[0]), 1);
        chk("mid_rst_wrap", int'(wr[0]), 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        mdl = '{0, 0};
        repeat (30) @(negedge Clk);
        chk("post_rst_out", int'(out0), 0);
        chk("post_rst_ready", int'(rdy[0]), 1);
        run_op(0, 3'b001, 4'd1, 12'h000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dekatron_step_counter.md
DEKATRON_STEP_COUNTER -- requirements
Module: dekatron_step_counter

Interface
REQ-001 SHALL have parameter D_NUM, default 3: number of BCD digits (decades).
REQ-002 SHALL have parameter TOP_LIMIT_MODE, default 1'b0: 1 = count range 0..TOP_VALUE; 0 = count range 0..all-nines.
REQ-003 SHALL have parameter TOP_VALUE, default {4'd5,4'd5,4'd5}: BCD wrap limit, D_NUM*4 bits wide.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 2: busy cycles after each step, emulating glow transfer (range 1..15).
REQ-005 SHALL have parameter WRITE_CYCLES, default 10: busy cycles for a parallel write (range 1..255).
REQ-006 SHALL have port Clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port Rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port Request, input, 1 bit: start an operation; accepted only while Ready=1.
REQ-009 SHALL have ports Dec, Set and SetZero, input, 1 bit each: operation select, sampled with Request.
REQ-010 SHALL have port Steps, input, 4 bits: number of unit steps for inc/dec.
REQ-011 SHALL have port In, input, D_NUM*4 bits: BCD load value.
REQ-012 SHALL have port Ready, output, 1 bit: idle and able to accept a request.
REQ-013 SHALL have ports Zero and AtTop, output, 1 bit each: Out==0 and Out==limit.
REQ-014 SHALL have port Wrap, output, 1 bit: one-cycle pulse on overflow or underflow.
REQ-015 SHALL have port Out, output, D_NUM*4 bits: current BCD count, registered.

Function
REQ-016 SHALL decode operation priority on acceptance as SetZero > Set > Dec > Inc.
REQ-017 SHALL implement states IDLE, STEP, SETTLE and WRITE; Ready SHALL equal (state==IDLE), registered.
REQ-018 SHALL, on accepted Inc/Dec, latch remaining=max(Steps,1) and enter STEP in the next cycle.
REQ-019 SHALL, in STEP, update Out by ±1 across all digits in one cycle with ripple BCD carry/borrow, decrement remaining and enter SETTLE.
REQ-020 SHALL remain in SETTLE for SETTLE_CYCLES cycles, then enter STEP if remaining>0, else IDLE.
REQ-021 SHALL therefore hold Ready low for N*(1+SETTLE_CYCLES)+1 cycles for an N-step operation.
REQ-022 SHALL use as limit TOP_VALUE when TOP_LIMIT_MODE=1, else all-nines.
REQ-023 SHALL wrap limit->0 on increment and 0->limit on decrement, pulsing Wrap in the STEP cycle of each wrap.
REQ-024 SHALL count normally, with wrap only at all-nines, when Out lies above TOP_VALUE.
REQ-025 SHALL, on Set or SetZero, enter WRITE, load Out from In (or zero) on the first WRITE cycle, hold for WRITE_CYCLES cycles and return to IDLE; Wrap SHALL stay 0.
REQ-026 SHALL clamp any In digit greater than 9 to 9 on load.
REQ-027 SHALL ignore Request, Dec, Set, SetZero, Steps and In while Ready=0.
REQ-028 SHALL update Zero and AtTop combinationally from registered Out.

Reset
REQ-029 SHALL asynchronously force Out=0, state=IDLE, remaining=0 and Wrap=0 when Rst_n=0, including mid-operation; Ready SHALL reset to 1 and Zero to 1.
REQ-030 SHALL not accept any request until the first rising Clk edge after Rst_n deasserts.

Configuration
REQ-031 SHALL compile multi-step support under macro DEKATRON_STEP_BULK_EN.
REQ-032 SHALL, with DEKATRON_STEP_BULK_EN defined, behave per REQ-018.
REQ-033 SHALL, without DEKATRON_STEP_BULK_EN, keep the Steps port but ignore it and always perform exactly one step.

Structure
REQ-034 SHALL take DEKATRON_WIDTH (=4), the BCD digit typedef and the state enum from the shared package dekatron_pkg.
REQ-035 SHALL instantiate one sub-module per digit, bcd_digit_step: combinational ±1 with carry/borrow in and out, plus per-digit clamp.

Verification (D_NUM=3, SETTLE_CYCLES=2, WRITE_CYCLES=10)
REQ-036 SHALL check: reset, then Inc with Steps=1 -> Out=001, Ready low for exactly 4 cycles.
REQ-037 SHALL check: Set with In=199, then Inc -> Out=200; SetZero with Set=1 -> Out=000 (SetZero wins).
REQ-038 SHALL check: TOP_LIMIT_MODE=1, TOP_VALUE=555, Out=555, Inc -> Out=000 with one Wrap pulse; Dec at 000 -> Out=555 with one Wrap pulse.
REQ-039 SHALL check: with DEKATRON_STEP_BULK_EN, Out=998 and Inc with Steps=5 -> Out=003 (all-nines mode), one Wrap pulse, Ready low 16 cycles; without the macro -> Out=999.
REQ-040 SHALL check: Set with In=0xA3F -> Out=939; a Request during WRITE is ignored.
REQ-041 SHALL check: Rst_n asserted during the SETTLE of the third step -> Out=000 and Ready=1 immediately, with no further steps after release.
